// File: rtl/lh_token_arbiter_if.sv
// Token handshake bundle between two upstream actors, the arbiter and the shared consumer.
// The slave modport is the arbiter's view; the master modport drives the requesters and the consumer.
interface lh_token_arbiter_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] In0_DATA;
  logic              In0_SEND;
  logic [15:0]       In0_COUNT;
  logic              In0_ACK;
  logic [DATA_W-1:0] In1_DATA;
  logic              In1_SEND;
  logic [15:0]       In1_COUNT;
  logic              In1_ACK;
  logic [DATA_W-1:0] Out_DATA;
  logic              Out_SEND;
  logic [15:0]       Out_COUNT;
  logic              Out_SRC;
  logic              Out_RDY;
  logic              Out_ACK;
  logic              Busy;

  modport slave (
    input  In0_DATA, In0_SEND, In0_COUNT,
    output In0_ACK,
    input  In1_DATA, In1_SEND, In1_COUNT,
    output In1_ACK,
    output Out_DATA, Out_SEND, Out_COUNT, Out_SRC, Busy,
    input  Out_RDY, Out_ACK
  );

  modport master (
    output In0_DATA, In0_SEND, In0_COUNT,
    input  In0_ACK,
    output In1_DATA, In1_SEND, In1_COUNT,
    input  In1_ACK,
    input  Out_DATA, Out_SEND, Out_COUNT, Out_SRC, Busy,
    output Out_RDY, Out_ACK
  );
endinterface

// File: rtl/lh_token_arbiter.sv
// Two-input burst-granular round-robin arbiter onto one token channel; a grant is held for
// BURST fires so each line reaches the consumer contiguous and tagged with its source.
module lh_token_arbiter #(
  parameter int DATA_W = 16,
  parameter int BURST  = 64,
  parameter int BCNT_W = 16
) (
  input logic                CLK,
  input logic                RESET,
  lh_token_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURST - 1);

  state_t            state, state_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic              last_src, last_src_nxt;
  logic [DATA_W-1:0] out_data, out_data_nxt;
  logic              out_send, out_send_nxt;
  logic              out_src, out_src_nxt;

  logic              gk;
  logic              send_k;
  logic              send_other;
  logic [DATA_W-1:0] data_k;
  logic              fire;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      bcnt     <= '0;
      last_src <= 1'b1;
      out_data <= '0;
      out_send <= 1'b0;
      out_src  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bcnt     <= bcnt_nxt;
      last_src <= last_src_nxt;
      out_data <= out_data_nxt;
      out_send <= out_send_nxt;
      out_src  <= out_src_nxt;
    end
  end

  // Both grant states share one datapath, steered by gk (1 = requester 1 granted).
  always_comb begin
    state_nxt    = state;
    bcnt_nxt     = bcnt;
    last_src_nxt = last_src;
    out_data_nxt = out_data;
    out_send_nxt = 1'b0;
    out_src_nxt  = out_src;

    gk         = (state == G1);
    send_k     = gk ? bus.In1_SEND : bus.In0_SEND;
    send_other = gk ? bus.In0_SEND : bus.In1_SEND;
    data_k     = gk ? bus.In1_DATA : bus.In0_DATA;
    fire       = (state != IDLE) && send_k && bus.Out_RDY;

    if (state == IDLE) begin
      bcnt_nxt = '0;
      if (bus.In0_SEND && bus.In1_SEND)
        state_nxt = last_src ? G0 : G1;
      else if (bus.In0_SEND)
        state_nxt = G0;
      else if (bus.In1_SEND)
        state_nxt = G1;
    end else if (fire) begin
      out_data_nxt = data_k;
      out_send_nxt = 1'b1;
      out_src_nxt  = gk;
      if (bcnt == BCNT_LAST) begin
        bcnt_nxt     = '0;
        last_src_nxt = gk;
        // A waiting peer takes over directly so back-to-back bursts have no bubble.
        if (send_other)
          state_nxt = gk ? G0 : G1;
        else
          state_nxt = IDLE;
      end else begin
        bcnt_nxt = bcnt + 1'b1;
      end
    end
  end

  assign bus.In0_ACK   = fire && !gk;
  assign bus.In1_ACK   = fire && gk;
  assign bus.Out_DATA  = out_data;
  assign bus.Out_SEND  = out_send;
  assign bus.Out_SRC   = out_src;
  assign bus.Out_COUNT = 16'h1;
  assign bus.Busy      = (state != IDLE);

endmodule

// File: tb/tb_lh_token_arbiter.sv
// Bench for lh_token_arbiter: a transaction-level grant/burst model predicts acks, Busy and
// the forwarded token for a BURST=4 instance; a BURST=1 instance covers per-token alternation.
module tb_lh_token_arbiter;
  localparam int DW = 16;
  localparam int B  = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  lh_token_arbiter_if #(.DATA_W(DW)) b4 ();
  lh_token_arbiter_if #(.DATA_W(DW)) b1 ();

  lh_token_arbiter #(.DATA_W(DW), .BURST(B), .BCNT_W(16)) dut4 (
    .CLK(CLK), .RESET(RESET), .bus(b4)
  );
  lh_token_arbiter #(.DATA_W(DW), .BURST(1), .BCNT_W(16)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(b1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the channel (-1 none), fires taken so far in this burst,
  // who finished the last burst, and the token expected on the output this cycle.
  int              m_grant;
  int              m_fires;
  int              m_last;
  logic            m_send;
  logic [DW-1:0]   m_data;
  logic            m_src;
  logic            e_ack0, e_ack1, e_busy;
  int              n0, n1;

  function automatic void model_reset();
    m_grant = -1; m_fires = 0; m_last = 1;
    m_send = 1'b0; m_data = '0; m_src = 1'b0;
  endfunction

  task automatic settle();
    @(negedge CLK);
    e_busy = (m_grant != -1);
    e_ack0 = (m_grant == 0) && b4.In0_SEND && b4.Out_RDY;
    e_ack1 = (m_grant == 1) && b4.In1_SEND && b4.Out_RDY;
  endtask

  task automatic advance();
    int k;
    logic sk, so, f;
    if (m_grant == -1) begin
      m_send = 1'b0;
      if (b4.In0_SEND && b4.In1_SEND) m_grant = 1 - m_last;
      else if (b4.In0_SEND)           m_grant = 0;
      else if (b4.In1_SEND)           m_grant = 1;
      m_fires = 0;
      @(posedge CLK); #1;
    end else begin
      k  = m_grant;
      sk = (k == 1) ? b4.In1_SEND : b4.In0_SEND;
      so = (k == 1) ? b4.In0_SEND : b4.In1_SEND;
      f  = sk && b4.Out_RDY;
      if (f) begin
        m_send = 1'b1;
        m_data = (k == 1) ? b4.In1_DATA : b4.In0_DATA;
        m_src  = (k == 1);
        m_fires++;
        if (m_fires == B) begin
          m_last  = k;
          m_fires = 0;
          m_grant = so ? 1 - k : -1;
        end
      end else begin
        m_send = 1'b0;
      end
      @(posedge CLK); #1;
      // A consumed token is replaced by the next one in the requester's sequence.
      if (f && k == 0) begin n0++; b4.In0_DATA = b4.In0_DATA + 1'b1; end
      if (f && k == 1) begin n1++; b4.In1_DATA = b4.In1_DATA + 1'b1; end
    end
  endtask

  task automatic apply_reset();
    b4.In0_SEND = 1'b0; b4.In1_SEND = 1'b0; b4.Out_RDY = 1'b0;
    b1.In0_SEND = 1'b0; b1.In1_SEND = 1'b0; b1.Out_RDY = 1'b0;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    n0 = 0; n1 = 0;
  endtask

  task automatic test_reset();
    model_reset();
    settle();
    checks++;
    if (b4.Out_SEND !== 1'b0 || b4.Out_DATA !== '0 || b4.Out_SRC !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: send=%b data=%h src=%b required 0/0000/0",
               b4.Out_SEND, b4.Out_DATA, b4.Out_SRC);
    end
    checks++;
    if (b4.Busy !== 1'b0 || b4.In0_ACK !== 1'b0 || b4.In1_ACK !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b ack0=%b ack1=%b required 0/0/0",
               b4.Busy, b4.In0_ACK, b4.In1_ACK);
    end
    checks++;
    if (b4.Out_COUNT !== 16'h1) begin
      errors++;
      $display("FAIL out_count: got %h required 0001", b4.Out_COUNT);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    n0 = 0; n1 = 0;
  endtask

  task automatic test_single();
    int nout = 0;
    int cyc[8];
    logic [DW-1:0] dat[8];
    logic src[8];
    b4.In0_DATA = 16'h10; b4.In0_SEND = 1'b1; b4.Out_RDY = 1'b1;
    for (int c = 0; c < 40 && nout < 8; c++) begin
      settle();
      checks++;
      if (b4.In0_ACK !== e_ack0 || b4.In1_ACK !== e_ack1 || b4.Busy !== e_busy) begin
        errors++;
        $display("FAIL single_ctl c%0d: ack0=%b ack1=%b busy=%b required %b/%b/%b",
                 c, b4.In0_ACK, b4.In1_ACK, b4.Busy, e_ack0, e_ack1, e_busy);
      end
      if (b4.Out_SEND === 1'b1) begin
        cyc[nout] = c; dat[nout] = b4.Out_DATA; src[nout] = b4.Out_SRC; nout++;
      end
      if (n0 >= 8) b4.In0_SEND = 1'b0;
      advance();
      if (n0 >= 8) b4.In0_SEND = 1'b0;
    end
    b4.In0_SEND = 1'b0;
    checks++;
    if (nout != 8) begin
      errors++;
      $display("FAIL single_count: got %0d tokens required 8", nout);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (dat[i] !== 16'(16'h10 + i) || src[i] !== 1'b0) begin
          errors++;
          $display("FAIL single_tok%0d: data=%h src=%b required %h/0", i, dat[i], src[i], 16'h10 + i);
        end
      end
      checks++;
      if (cyc[0] != 2 || cyc[3] != 5 || cyc[4] != 7 || cyc[7] != 10) begin
        errors++;
        $display("FAIL single_timing: cycles %0d %0d %0d %0d required 2 5 7 10",
                 cyc[0], cyc[3], cyc[4], cyc[7]);
      end
    end
  endtask

  task automatic test_both();
    int nout = 0;
    int cyc[16];
    logic src[16];
    apply_reset();
    b4.In0_DATA = 16'(($urandom & 16'h00ff));
    b4.In1_DATA = 16'(($urandom & 16'h00ff) | 16'h8000);
    b4.In0_SEND = 1'b1; b4.In1_SEND = 1'b1; b4.Out_RDY = 1'b1;
    for (int c = 0; c < 40 && nout < 16; c++) begin
      settle();
      checks++;
      if (b4.In0_ACK !== e_ack0 || b4.In1_ACK !== e_ack1 || b4.Busy !== e_busy) begin
        errors++;
        $display("FAIL both_ctl c%0d: ack0=%b ack1=%b busy=%b required %b/%b/%b",
                 c, b4.In0_ACK, b4.In1_ACK, b4.Busy, e_ack0, e_ack1, e_busy);
      end
      checks++;
      if (b4.Out_SEND !== m_send || (m_send && (b4.Out_DATA !== m_data || b4.Out_SRC !== m_src))) begin
        errors++;
        $display("FAIL both_out c%0d: send=%b data=%h src=%b required %b/%h/%b",
                 c, b4.Out_SEND, b4.Out_DATA, b4.Out_SRC, m_send, m_data, m_src);
      end
      checks++;
      if (b4.In0_ACK === 1'b1 && b4.In1_ACK === 1'b1) begin
        errors++;
        $display("FAIL both_ack_excl c%0d: ack0=1 ack1=1 required not both", c);
      end
      if (b4.Out_SEND === 1'b1) begin
        cyc[nout] = c; src[nout] = b4.Out_SRC; nout++;
      end
      advance();
    end
    b4.In0_SEND = 1'b0; b4.In1_SEND = 1'b0;
    checks++;
    if (nout != 16) begin
      errors++;
      $display("FAIL both_count: got %0d tokens required 16", nout);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (src[i] !== 1'((i / 4) % 2) || cyc[i] != cyc[0] + i) begin
          errors++;
          $display("FAIL both_pattern%0d: src=%b cyc=%0d required %0d/%0d",
                   i, src[i], cyc[i], (i / 4) % 2, cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic prev_fire = 1'b0;
    logic seen_busy = 1'b0;
    int   fires = 0;
    int   c;
    apply_reset();
    b4.In1_DATA = 16'h0a00; b4.In1_SEND = 1'b1;
    for (c = 0; c < 30; c++) begin
      b4.Out_RDY = ~c[0];
      settle();
      checks++;
      if (b4.In0_ACK !== e_ack0 || b4.In1_ACK !== e_ack1 || b4.Busy !== e_busy) begin
        errors++;
        $display("FAIL bp_ctl c%0d: ack0=%b ack1=%b busy=%b required %b/%b/%b",
                 c, b4.In0_ACK, b4.In1_ACK, b4.Busy, e_ack0, e_ack1, e_busy);
      end
      checks++;
      if (b4.Out_SEND !== prev_fire || (prev_fire && (b4.Out_DATA !== m_data || b4.Out_SRC !== 1'b1))) begin
        errors++;
        $display("FAIL bp_out c%0d: send=%b data=%h src=%b required %b/%h/1",
                 c, b4.Out_SEND, b4.Out_DATA, b4.Out_SRC, prev_fire, m_data);
      end
      if (e_busy) begin
        checks++;
        if (b4.In1_ACK !== b4.In1_SEND && b4.Out_RDY) begin
          errors++;
          $display("FAIL bp_ack_follow c%0d: ack1=%b required %b", c, b4.In1_ACK, b4.Out_RDY);
        end
      end
      if (b4.Busy === 1'b1) seen_busy = 1'b1;
      if (seen_busy && b4.Busy === 1'b0) break;
      prev_fire = e_ack1;
      if (e_ack1) fires++;
      advance();
      if (n1 >= 4) b4.In1_SEND = 1'b0;
    end
    checks++;
    if (fires != 4 || c >= 30) begin
      errors++;
      $display("FAIL bp_burst_len: fires=%0d cycles=%0d required 4 fires within budget", fires, c);
    end
  endtask

  task automatic test_starve();
    int nout = 0;
    int gap = 0;
    logic src[6];
    apply_reset();
    b4.In0_DATA = 16'h0100; b4.In1_DATA = 16'h0200;
    b4.In0_SEND = 1'b1; b4.In1_SEND = 1'b0; b4.Out_RDY = 1'b1;
    for (int c = 0; c < 40 && nout < 6; c++) begin
      settle();
      checks++;
      if (b4.In0_ACK !== e_ack0 || b4.In1_ACK !== e_ack1 || b4.Busy !== e_busy) begin
        errors++;
        $display("FAIL starve_ctl c%0d: ack0=%b ack1=%b busy=%b required %b/%b/%b",
                 c, b4.In0_ACK, b4.In1_ACK, b4.Busy, e_ack0, e_ack1, e_busy);
      end
      if (n0 < 4) begin
        checks++;
        if (b4.In1_ACK !== 1'b0) begin
          errors++;
          $display("FAIL starve_hold c%0d: ack1=%b required 0 during In0 burst", c, b4.In1_ACK);
        end
      end
      if (b4.Out_SEND === 1'b1) begin
        src[nout] = b4.Out_SRC; nout++;
      end
      advance();
      if (n0 == 2 && gap < 5) begin
        b4.In0_SEND = 1'b0; b4.In1_SEND = 1'b1; gap++;
      end else begin
        b4.In0_SEND = (n0 < 4);
      end
    end
    b4.In0_SEND = 1'b0; b4.In1_SEND = 1'b0;
    checks++;
    if (nout != 6 || gap != 5) begin
      errors++;
      $display("FAIL starve_count: tokens=%0d gap=%0d required 6/5", nout, gap);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (src[i] !== (i >= 4)) begin
          errors++;
          $display("FAIL starve_src%0d: got %b required %0d", i, src[i], i >= 4);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    apply_reset();
    b4.In0_DATA = 16'h0300; b4.In1_DATA = 16'h0400;
    b4.In0_SEND = 1'b1; b4.In1_SEND = 1'b1; b4.Out_RDY = 1'b1;
    for (c = 0; c < 30 && n1 < 2; c++) begin
      settle();
      advance();
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (b4.Out_SEND !== 1'b0 || b4.Busy !== 1'b0 || dut4.bcnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_async: send=%b busy=%b bcnt=%0d required 0/0/0 (n1=%0d)",
               b4.Out_SEND, b4.Busy, dut4.bcnt, n1);
    end
    checks++;
    if (b4.In0_ACK !== 1'b0 || b4.In1_ACK !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ack: ack0=%b ack1=%b required 0/0", b4.In0_ACK, b4.In1_ACK);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    for (c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (b4.In0_ACK !== e_ack0 || b4.In1_ACK !== e_ack1 || b4.Busy !== e_busy) begin
        errors++;
        $display("FAIL rstmid_regrant c%0d: ack0=%b ack1=%b busy=%b required %b/%b/%b",
                 c, b4.In0_ACK, b4.In1_ACK, b4.Busy, e_ack0, e_ack1, e_busy);
      end
      checks++;
      if (b4.Out_SEND !== m_send || (m_send && (b4.Out_DATA !== m_data || b4.Out_SRC !== m_src))) begin
        errors++;
        $display("FAIL rstmid_out c%0d: send=%b data=%h src=%b required %b/%h/%b",
                 c, b4.Out_SEND, b4.Out_DATA, b4.Out_SRC, m_send, m_data, m_src);
      end
      if (c == 1) begin
        checks++;
        if (b4.In0_ACK !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_first: ack0=%b required 1 after reset tie", b4.In0_ACK);
        end
      end
      advance();
    end
    b4.In0_SEND = 1'b0; b4.In1_SEND = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    b4.In0_DATA = 16'($urandom); b4.In1_DATA = 16'($urandom);
    for (int c = 0; c < 400; c++) begin
      b4.In0_SEND  = ($urandom_range(0, 3) != 0);
      b4.In1_SEND  = ($urandom_range(0, 2) != 0);
      b4.Out_RDY   = ($urandom_range(0, 4) != 0);
      b4.In0_COUNT = 16'($urandom);
      b4.In1_COUNT = 16'($urandom);
      b4.Out_ACK   = 1'($urandom);
      settle();
      checks++;
      if (b4.In0_ACK !== e_ack0 || b4.In1_ACK !== e_ack1 || b4.Busy !== e_busy) begin
        errors++;
        $display("FAIL rand_ctl c%0d: ack0=%b ack1=%b busy=%b required %b/%b/%b",
                 c, b4.In0_ACK, b4.In1_ACK, b4.Busy, e_ack0, e_ack1, e_busy);
      end
      checks++;
      if (b4.Out_SEND !== m_send || (m_send && (b4.Out_DATA !== m_data || b4.Out_SRC !== m_src))) begin
        errors++;
        $display("FAIL rand_out c%0d: send=%b data=%h src=%b required %b/%h/%b",
                 c, b4.Out_SEND, b4.Out_DATA, b4.Out_SRC, m_send, m_data, m_src);
      end
      advance();
    end
    b4.In0_SEND = 1'b0; b4.In1_SEND = 1'b0;
    b4.In0_COUNT = 16'h1; b4.In1_COUNT = 16'h1; b4.Out_ACK = 1'b0;
  endtask

  task automatic test_burst1();
    int nout = 0;
    int cyc[8];
    logic src[8];
    apply_reset();
    b1.In0_DATA = 16'h0500; b1.In1_DATA = 16'h0600;
    b1.In0_SEND = 1'b1; b1.In1_SEND = 1'b1; b1.Out_RDY = 1'b1;
    for (int c = 0; c < 20 && nout < 8; c++) begin
      @(negedge CLK);
      if (b1.Out_SEND === 1'b1) begin
        cyc[nout] = c; src[nout] = b1.Out_SRC; nout++;
      end
      @(posedge CLK); #1;
    end
    b1.In0_SEND = 1'b0; b1.In1_SEND = 1'b0;
    checks++;
    if (nout != 8) begin
      errors++;
      $display("FAIL b1_count: got %0d tokens required 8", nout);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (src[i] !== 1'(i % 2) || cyc[i] != cyc[0] + i) begin
          errors++;
          $display("FAIL b1_alt%0d: src=%b cyc=%0d required %0d/%0d",
                   i, src[i], cyc[i], i % 2, cyc[0] + i);
        end
      end
    end
  endtask

  initial begin
    b4.In0_DATA = '0; b4.In0_SEND = 1'b0; b4.In0_COUNT = 16'h1;
    b4.In1_DATA = '0; b4.In1_SEND = 1'b0; b4.In1_COUNT = 16'h1;
    b4.Out_RDY = 1'b0; b4.Out_ACK = 1'b0;
    b1.In0_DATA = '0; b1.In0_SEND = 1'b0; b1.In0_COUNT = 16'h1;
    b1.In1_DATA = '0; b1.In1_SEND = 1'b0; b1.In1_COUNT = 16'h1;
    b1.Out_RDY = 1'b0; b1.Out_ACK = 1'b0;
    test_reset();
    test_single();
    test_both();
    test_backpressure();
    test_starve();
    test_reset_mid();
    test_random();
    test_burst1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lh_token_arbiter.md
# lh_token_arbiter

Two-input, burst-granular round-robin arbiter that shares a single downstream token channel between two upstream actor outputs in the visual-saliency pipeline, e.g. two LH-stage filter instances feeding one shared consumer. Grants are held for BURST tokens, normally one image line, so lines arrive at the consumer contiguous and tagged with their source. It uses the same DATA/SEND/ACK/RDY/COUNT token handshake as the generated actors and sits between them with no glue logic.

## Interface
Parameters:
- DATA_W, 16, token data width
- BURST, 64, tokens per grant (≥1), normally the line width
- BCNT_W, 16, burst counter width; BURST−1 must fit

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  reset, asynchronous, active-high; clock CLK
- In0_DATA  in  DATA_W  token from requester 0
- In0_SEND  in  1  requester 0 has a token
- In0_COUNT  in  16  ignored (always 1 upstream)
- In0_ACK  out  1  token on In0 consumed this cycle
- In1_DATA / In1_SEND / In1_COUNT / In1_ACK  same for requester 1
- Out_DATA  out  DATA_W  forwarded token
- Out_SEND  out  1  Out_DATA valid, one-cycle pulse per token
- Out_COUNT  out  16  constant 16'h1
- Out_SRC  out  1  source of the token on Out_DATA, valid with Out_SEND
- Out_RDY  in  1  consumer can accept a token next cycle
- Out_ACK  in  1  ignored, kept for port compatibility
- Busy  out  1  high while state is not IDLE

## Operation
- States: IDLE, G0 (requester 0 granted), G1 (requester 1 granted). Registers: state, bcnt (BCNT_W bits), last_src (1 bit), output register (DATA, SEND, SRC).
- IDLE: no transfer takes place.
  - If only In0_SEND is high, go to G0. If only In1_SEND is high, go to G1.
  - If both are high, grant the requester ≠ last_src.
  - If neither is high, stay in IDLE.
  - bcnt is cleared on every IDLE cycle.
- Gk fire condition: fire = Ink_SEND & Out_RDY.
  - On fire: Ink_ACK=1 combinationally in the same cycle. The output register loads Ink_DATA and SRC=k, and SEND=1 next cycle. bcnt increments.
  - No fire: Ink_ACK=0, and the output SEND register loads 0.
  - The non-granted In_ACK is always 0.
- Burst end is fire with bcnt==BURST−1. On that cycle:
  - last_src←k and bcnt←0.
  - If the other requester's SEND is high in that same cycle, switch directly to the other grant state with no IDLE bubble.
  - Otherwise go to IDLE.
- The grant is held for the whole burst, even if Ink_SEND drops mid-burst. The arbiter waits in Gk indefinitely, with no timeout, to keep lines atomic.
- BURST=1 degenerates to per-token round-robin with switches on every token.
- Out_COUNT is driven 16'h1 at all times. In*_COUNT and Out_ACK have no effect.

## Timing
- Reset values: state=IDLE, bcnt=0, last_src=1 (requester 0 wins the first tie), Out_SEND=0, Out_DATA=0, Out_SRC=0, Busy=0, In0_ACK=In1_ACK=0.
- Reset asserted mid-burst:
  - All registers clear immediately and asynchronously.
  - A token in the output register is dropped, and Out_SEND falls without waiting for a clock edge.
  - The partial burst is abandoned.
- Latency: a token fired in cycle t appears on Out_DATA/Out_SEND/Out_SRC in cycle t+1 for exactly one cycle.
- Out_RDY is sampled only in the fire cycle. The consumer must guarantee space for a token arriving one cycle later.
- Grant acquisition from IDLE costs one cycle, so the first token fires no earlier than the cycle after entering Gk.
- Throughput: 1 token/cycle sustained within a burst. Back-to-back bursts between requesters incur no bubble.
- In_ACK is combinational from SEND, RDY and state. There is no combinational path from In*_DATA to any output.

## Test plan
- Single requester, BURST=4: In0_SEND held high with data 0x10..0x17, Out_RDY=1. Expected:
  - IDLE→G0 in 1 cycle, then Out_DATA = 0x10..0x13 at consecutive cycles, Out_SRC=0.
  - Back to IDLE for 1 cycle, then a re-grant to G0, then 0x14..0x17.
- Both requesters continuously valid, BURST=4. Expected:
  - Out_SRC pattern 0000 1111 0000…, with no bubble at the switches.
  - The first grant goes to requester 0.
  - In0_ACK and In1_ACK are never high together.
- Back-pressure: Out_RDY toggles 1,0,1,0 during a G1 burst. Expected:
  - In1_ACK and the next-cycle Out_SEND follow Out_RDY exactly.
  - bcnt advances only on fires, so the burst completes after 4 fires.
- Mid-burst starvation, BURST=4: In0 sends 2 tokens, drops SEND for 5 cycles while In1_SEND=1, then resumes. Expected:
  - The grant stays G0 and In1_ACK remains 0 throughout.
  - Tokens 3 and 4 come from In0, and only then does the grant switch to G1.
- Reset mid-burst: assert RESET for 1 cycle after the 2nd fire of a burst. Expected:
  - Out_SEND=0 and Busy=0 immediately; bcnt=0.
  - After release, a simultaneous request grants requester 0.
- BURST=1, both requesters valid: Out_SRC alternates 0,1,0,1 at 1 token/cycle.
